// File: rtl/aes_decryption_core.sv
// ---------------------------------------------------------------------------
// aes_decryption_core -- iterative AES-128 decryption, one round per cycle.
//
// Ports:
//   clk         rising-edge clock for all state
//   rst         synchronous active-high reset
//   in_valid    ciphertext/key offered this cycle
//   in_ready    high only in IDLE; a job is accepted on in_valid && in_ready
//   key         cipher key, byte 0 = key[127:120]
//   key_reuse   at accept, skip expansion and reuse stored round keys
//   ciphertext  block to decrypt, byte 0 = [127:120], column-major state
//   plaintext   registered result, valid while out_valid is high
//   out_valid   result valid, held until an edge with out_ready = 1
//   out_ready   consumer accepts plaintext
//   busy        high in KEYEXP, INIT and ROUND
//
// Also contains aes_sbox / aes_inv_sbox byte substitution tables.
// ---------------------------------------------------------------------------

// Forward AES S-box (byte 0x00 occupies the most significant table byte).
module aes_sbox (
    input  logic [7:0] a_i,
    output logic [7:0] y_o
);
    localparam logic [2047:0] TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Entry b sits at bits [8*(255-b)+7 -: 8]; 8*(255-b)+7 == {~b, 3'b111}.
    assign y_o = TBL[{~a_i, 3'b111} -: 8];
endmodule

// Inverse AES S-box, same table layout as aes_sbox.
module aes_inv_sbox (
    input  logic [7:0] a_i,
    output logic [7:0] y_o
);
    localparam logic [2047:0] TBL = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    assign y_o = TBL[{~a_i, 3'b111} -: 8];
endmodule

module aes_decryption_core (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] key,
    input  logic         key_reuse,
    input  logic [127:0] ciphertext,
    output logic [127:0] plaintext,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         busy
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_KEYEXP = 3'd1;
    localparam logic [2:0] S_INIT   = 3'd2;
    localparam logic [2:0] S_ROUND  = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    // ------------------------------------------------------------------
    // GF(2^8) helpers, reduction polynomial 0x11B
    // ------------------------------------------------------------------
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] c);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int unsigned i = 0; i < 4; i++) begin
            if (c[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        return {gmul(a0, 4'he) ^ gmul(a1, 4'hb) ^ gmul(a2, 4'hd) ^ gmul(a3, 4'h9),
                gmul(a0, 4'h9) ^ gmul(a1, 4'he) ^ gmul(a2, 4'hb) ^ gmul(a3, 4'hd),
                gmul(a0, 4'hd) ^ gmul(a1, 4'h9) ^ gmul(a2, 4'he) ^ gmul(a3, 4'hb),
                gmul(a0, 4'hb) ^ gmul(a1, 4'hd) ^ gmul(a2, 4'h9) ^ gmul(a3, 4'he)};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] i);
        case (i)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [2:0]   fsm_q, fsm_d;
    logic [3:0]   rnd_q, rnd_d;
    logic [127:0] data_q, data_d;
    logic [127:0] pt_q, pt_d;
    logic         ov_q, ov_d;
    logic         kl_q, kl_d;         // round keys rk[0..10] are complete
    logic [127:0] rk_q [0:10];

    logic         rk_we;
    logic [3:0]   rk_widx;
    logic [127:0] rk_wdata;

    // ------------------------------------------------------------------
    // Key expansion: rk[rnd] from rk[rnd-1]
    // ------------------------------------------------------------------
    logic [127:0] kprev;
    logic [31:0]  rot_w, sub_w, temp_w;
    logic [31:0]  kw0, kw1, kw2, kw3;
    logic [127:0] knext;

    assign kprev = rk_q[rnd_q - 4'd1];
    assign rot_w = {kprev[23:0], kprev[31:24]};

    for (genvar g = 0; g < 4; g++) begin : g_ksbox
        aes_sbox u_sbox (
            .a_i (rot_w[31-8*g -: 8]),
            .y_o (sub_w[31-8*g -: 8])
        );
    end

    assign temp_w = sub_w ^ {rcon(rnd_q), 24'h000000};
    assign kw0    = kprev[127:96] ^ temp_w;
    assign kw1    = kprev[95:64]  ^ kw0;
    assign kw2    = kprev[63:32]  ^ kw1;
    assign kw3    = kprev[31:0]   ^ kw2;
    assign knext  = {kw0, kw1, kw2, kw3};

    // ------------------------------------------------------------------
    // Decryption round datapath
    // ------------------------------------------------------------------
    logic [7:0]   isr_b [16];
    logic [7:0]   isb_b [16];
    logic [127:0] rk_sel;
    logic [127:0] ark;
    logic [127:0] imc;
    logic [127:0] round_out;

    // InvShiftRows: row r rotates right by r, so out[r][c] = in[r][(c-r) mod 4].
    always_comb begin
        for (int unsigned c = 0; c < 4; c++) begin
            for (int unsigned r = 0; r < 4; r++) begin
                isr_b[4*c+r] = data_q[127 - 8*(4*((c + 4 - r) % 4) + r) -: 8];
            end
        end
    end

    for (genvar g = 0; g < 16; g++) begin : g_isbox
        aes_inv_sbox u_isbox (
            .a_i (isr_b[g]),
            .y_o (isb_b[g])
        );
    end

    assign rk_sel = rk_q[rnd_q];

    always_comb begin
        ark = '0;
        for (int unsigned k = 0; k < 16; k++) begin
            ark[127-8*k -: 8] = isb_b[k] ^ rk_sel[127-8*k -: 8];
        end
    end

    always_comb begin
        imc = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            imc[127-32*c -: 32] = inv_mix_col(ark[127-32*c -: 32]);
        end
    end

    assign round_out = (rnd_q == 4'd0) ? ark : imc;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        fsm_d    = fsm_q;
        rnd_d    = rnd_q;
        data_d   = data_q;
        pt_d     = pt_q;
        ov_d     = ov_q;
        kl_d     = kl_q;
        rk_we    = 1'b0;
        rk_widx  = '0;
        rk_wdata = '0;

        case (fsm_q)
            S_IDLE: begin
                if (in_valid) begin
                    data_d = ciphertext;
                    if (key_reuse && kl_q) begin
                        fsm_d = S_INIT;
                    end else begin
                        // Starting a fresh schedule invalidates the stored keys
                        // until rk[10] is written again.
                        rk_we    = 1'b1;
                        rk_widx  = 4'd0;
                        rk_wdata = key;
                        kl_d     = 1'b0;
                        rnd_d    = 4'd1;
                        fsm_d    = S_KEYEXP;
                    end
                end
            end
            S_KEYEXP: begin
                rk_we    = 1'b1;
                rk_widx  = rnd_q;
                rk_wdata = knext;
                if (rnd_q == 4'd10) begin
                    kl_d  = 1'b1;
                    fsm_d = S_INIT;
                end else begin
                    rnd_d = rnd_q + 4'd1;
                end
            end
            S_INIT: begin
                data_d = data_q ^ rk_q[10];
                rnd_d  = 4'd9;
                fsm_d  = S_ROUND;
            end
            S_ROUND: begin
                data_d = round_out;
                if (rnd_q == 4'd0) begin
                    pt_d  = round_out;
                    ov_d  = 1'b1;
                    fsm_d = S_DONE;
                end else begin
                    rnd_d = rnd_q - 4'd1;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    ov_d  = 1'b0;
                    fsm_d = S_IDLE;
                end
            end
            default: fsm_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q  <= S_IDLE;
            rnd_q  <= '0;
            data_q <= '0;
            pt_q   <= '0;
            ov_q   <= 1'b0;
            kl_q   <= 1'b0;
        end else begin
            fsm_q  <= fsm_d;
            rnd_q  <= rnd_d;
            data_q <= data_d;
            pt_q   <= pt_d;
            ov_q   <= ov_d;
            kl_q   <= kl_d;
        end
    end

    // Round-key storage has no reset; keys_loaded gates its use.
    always_ff @(posedge clk) begin
        if (!rst && rk_we) begin
            rk_q[rk_widx] <= rk_wdata;
        end
    end

    assign in_ready  = (fsm_q == S_IDLE);
    assign busy      = (fsm_q == S_KEYEXP) || (fsm_q == S_INIT) || (fsm_q == S_ROUND);
    assign plaintext = pt_q;
    assign out_valid = ov_q;

endmodule

// File: tb/tb_aes_decryption_core.sv
// ---------------------------------------------------------------------------
// tb_aes_decryption_core -- directed bench for aes_decryption_core using the
// FIPS-197 C.1 and Appendix B vectors, key reuse, backpressure and reset
// abort scenarios.
// ---------------------------------------------------------------------------
module tb_aes_decryption_core;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] key;
    logic         key_reuse;
    logic [127:0] ciphertext;
    logic [127:0] plaintext;
    logic         out_valid;
    logic         out_ready;
    logic         busy;

    int checks   = 0;
    int failures = 0;
    int lat;
    int seen_ov;

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

    aes_decryption_core dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .key        (key),
        .key_reuse  (key_reuse),
        .ciphertext (ciphertext),
        .plaintext  (plaintext),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Offer one job; returns #1 after the accept edge with inputs scrambled.
    task automatic launch(input logic [127:0] k, input logic [127:0] ct, input logic reuse);
        @(negedge clk);
        key        = k;
        ciphertext = ct;
        key_reuse  = reuse;
        in_valid   = 1'b1;
        @(posedge clk);
        #1;
        in_valid   = 1'b0;
        key        = ~k;
        ciphertext = ~ct;
        key_reuse  = 1'b0;
    endtask

    // Counts edges after the accept edge until out_valid is seen (bounded).
    task automatic wait_out(output int edges);
        int found;
        found = 0;
        edges = 0;
        for (int i = 0; i < 60 && found == 0; i++) begin
            @(posedge clk);
            #1;
            edges++;
            if (out_valid) found = 1;
        end
        if (found == 0) edges = -1;
    endtask

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b1;          // accept attempt during reset must lose
        key        = C1_KEY;
        key_reuse  = 1'b0;
        ciphertext = C1_CT;
        out_ready  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_plaintext", plaintext, '0);
        chk("rst_busy",      128'(busy), 128'(0));
        chk("rst_in_ready",  128'(in_ready), 128'(1));
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // FIPS-197 C.1, full expansion
        launch(C1_KEY, C1_CT, 1'b0);
        chk("c1_busy_after_A",     128'(busy), 128'(1));
        chk("c1_in_ready_after_A", 128'(in_ready), 128'(0));
        wait_out(lat);
        chk("c1_latency",   128'(lat), 128'(21));
        chk("c1_plaintext", plaintext, C1_PT);
        @(posedge clk);
        #1;
        chk("c1_ov_cleared", 128'(out_valid), 128'(0));
        chk("c1_in_ready",   128'(in_ready), 128'(1));

        // FIPS-197 Appendix B, full expansion
        launch(B_KEY, B_CT, 1'b0);
        wait_out(lat);
        chk("b_latency",   128'(lat), 128'(21));
        chk("b_plaintext", plaintext, B_PT);
        @(posedge clk);
        #1;

        // Appendix B again with stored keys and a zero key input
        launch(128'h0, B_CT, 1'b1);
        wait_out(lat);
        chk("b_reuse_latency",   128'(lat), 128'(11));
        chk("b_reuse_plaintext", plaintext, B_PT);
        @(posedge clk);
        #1;

        // Backpressure: out_ready low for 5 cycles, in_valid pulses ignored
        out_ready = 1'b0;
        launch(128'h0, B_CT, 1'b1);
        wait_out(lat);
        chk("bp_latency", 128'(lat), 128'(11));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid   = 1'b1;
            ciphertext = {$urandom, $urandom, $urandom, $urandom};
            @(posedge clk);
            #1;
            chk("bp_plaintext_hold", plaintext, B_PT);
            chk("bp_out_valid_hold", 128'(out_valid), 128'(1));
            chk("bp_in_ready_low",   128'(in_ready), 128'(0));
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_ov_cleared", 128'(out_valid), 128'(0));
        chk("bp_in_ready",   128'(in_ready), 128'(1));
        chk("bp_no_accept",  128'(busy), 128'(0));

        // Back-to-back: C.1 after App. B replaces the round keys
        launch(C1_KEY, C1_CT, 1'b0);
        wait_out(lat);
        chk("b2b_latency",   128'(lat), 128'(21));
        chk("b2b_plaintext", plaintext, C1_PT);
        @(posedge clk);
        #1;

        // Reset at edge A+8 of a C.1 job (inside key expansion)
        launch(C1_KEY, C1_CT, 1'b0);
        repeat (6) @(posedge clk);       // edges A+1 .. A+7 (A+1 consumed below)
        @(posedge clk);
        @(negedge clk);
        chk("abort_busy_before", 128'(busy), 128'(1));
        rst = 1'b1;
        @(posedge clk);                  // edge A+8 with rst high
        #1;
        chk("abort_out_valid", 128'(out_valid), 128'(0));
        chk("abort_plaintext", plaintext, '0);
        chk("abort_busy",      128'(busy), 128'(0));
        chk("abort_in_ready",  128'(in_ready), 128'(1));
        @(negedge clk);
        rst = 1'b0;
        seen_ov = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen_ov = 1;
        end
        chk("abort_no_output", 128'(seen_ov), 128'(0));

        // key_reuse after reset must fall back to full expansion
        launch(C1_KEY, C1_CT, 1'b1);
        wait_out(lat);
        chk("post_rst_latency",   128'(lat), 128'(21));
        chk("post_rst_plaintext", plaintext, C1_PT);
        @(posedge clk);
        #1;
        chk("post_rst_in_ready", 128'(in_ready), 128'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
